fetch_resp: RTL and testbench



---
 rtl/fetch_resp.sv | 152 +++++++++++++++
 tb/tb_fetch_resp.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_resp.sv
// fetch_resp: instruction-fetch responder for the 16-bit datapath.
// Accepts a byte address on req/!busy/!flush and returns the addressed
// 16-bit word from a word-organised store LATENCY cycles later, marked by a
// one-cycle valid pulse. Misaligned and out-of-range fetches return the NOP
// word 16'h0800 (err set for misaligned). A flush aborts a waiting fetch.
//
// Optional feature macro: FETCH_RESP_WR_FWD_EN
//   defined   - store writes hitting the index of a pending fetch (on the
//               accept edge or any edge while waiting) update the returned word.
//   undefined - the returned word is the one snapshotted at the accept edge.
module fetch_resp #(
  parameter int LATENCY    = 2,
  parameter int DEPTH_LOG2 = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req,
  input  logic [15:0] addr,
  input  logic        flush,
  input  logic        wr_en,
  input  logic [15:0] wr_addr,
  input  logic [15:0] wr_data,
  output logic [15:0] instr,
  output logic        valid,
  output logic        busy,
  output logic        err
);

  localparam int          WORDS    = 1 << DEPTH_LOG2;
  localparam logic [15:0] NOP_WORD = 16'h0800;
  localparam logic [3:0]  CNT_LOAD = 4'(LATENCY - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t      state;
  logic [3:0]  cnt;
  logic        mis_pend;
  logic [15:0] mem [WORDS];

  logic [DEPTH_LOG2-1:0] rd_idx;
  logic [DEPTH_LOG2-1:0] wr_idx;
  logic                  rd_oor;
  logic                  wr_oor;
  logic                  accept;
  logic [15:0]           rd_word;

`ifdef FETCH_RESP_WR_FWD_EN
  logic [DEPTH_LOG2-1:0] fwd_idx;
  logic                  fwd_ok;
`endif

  // The byte-select bit of the write address carries no information.
  logic unused_wr_lsb;
  assign unused_wr_lsb = wr_addr[0];

  // Address decode, acceptance and the word captured on acceptance.
  always_comb begin
    rd_idx  = addr[DEPTH_LOG2:1];
    wr_idx  = wr_addr[DEPTH_LOG2:1];
    rd_oor  = (addr >> (DEPTH_LOG2 + 1)) != 16'h0000;
    wr_oor  = (wr_addr >> (DEPTH_LOG2 + 1)) != 16'h0000;
    accept  = req && !busy && !flush;
    rd_word = (rd_oor || addr[0]) ? NOP_WORD : mem[rd_idx];
  end

  // Instruction store write port; out-of-range writes are dropped.
  always_ff @(posedge clk) begin
    if (wr_en && !wr_oor) begin
      mem[wr_idx] <= wr_data;
    end
  end

  // Fetch FSM with registered outputs; instr doubles as the data register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      cnt      <= '0;
      instr    <= '0;
      valid    <= 1'b0;
      busy     <= 1'b0;
      err      <= 1'b0;
      mis_pend <= 1'b0;
`ifdef FETCH_RESP_WR_FWD_EN
      fwd_idx  <= '0;
      fwd_ok   <= 1'b0;
`endif
    end else begin
      valid <= 1'b0;
      busy  <= 1'b0;
      err   <= 1'b0;
      case (state)
        // Counter steps down on every waiting edge; the edge that takes it
        // from 1 to 0 is the one that raises valid.
        WAIT: begin
          if (flush) begin
            state <= IDLE;
            cnt   <= '0;
          end else if (cnt == 4'd1) begin
            state <= RESP;
            cnt   <= '0;
            valid <= 1'b1;
            err   <= mis_pend;
          end else begin
            cnt  <= cnt - 4'd1;
            busy <= 1'b1;
          end
        end
        IDLE, RESP: begin
          if (accept) begin
            instr    <= rd_word;
            mis_pend <= addr[0];
`ifdef FETCH_RESP_WR_FWD_EN
            fwd_idx  <= rd_idx;
            fwd_ok   <= !rd_oor && !addr[0];
`endif
            if (LATENCY == 1) begin
              state <= RESP;
              valid <= 1'b1;
              err   <= addr[0];
            end else begin
              state <= WAIT;
              busy  <= 1'b1;
              cnt   <= CNT_LOAD;
            end
          end else begin
            state <= IDLE;
            cnt   <= '0;
          end
        end
        default: begin
          state <= IDLE;
          cnt   <= '0;
        end
      endcase
`ifdef FETCH_RESP_WR_FWD_EN
      // Later assignment wins over the snapshot taken on the accept edge.
      if (wr_en && !wr_oor) begin
        if (accept && !rd_oor && !addr[0] && (wr_idx == rd_idx)) begin
          instr <= wr_data;
        end else if ((state == WAIT) && fwd_ok && (wr_idx == fwd_idx)) begin
          instr <= wr_data;
        end
      end
`endif
    end
  end

endmodule

// File: tb/tb_fetch_resp.sv
// Bench for fetch_resp: three instances (LATENCY 2, 1, 4) share one stimulus
// stream; a per-fetch countdown model predicts valid/busy/instr/err.
module tb_fetch_resp;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req;
  logic [15:0] addr;
  logic        flush;
  logic        wr_en;
  logic [15:0] wr_addr;
  logic [15:0] wr_data;

  logic [15:0] instr_o [3];
  logic [2:0]  valid_o;
  logic [2:0]  busy_o;
  logic [2:0]  err_o;

  int lat [3] = '{2, 1, 4};

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  fetch_resp #(.LATENCY(2), .DEPTH_LOG2(8)) u_l2 (
    .clk(clk), .rst_n(rst_n), .req(req), .addr(addr), .flush(flush),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .instr(instr_o[0]), .valid(valid_o[0]), .busy(busy_o[0]), .err(err_o[0])
  );

  fetch_resp #(.LATENCY(1), .DEPTH_LOG2(8)) u_l1 (
    .clk(clk), .rst_n(rst_n), .req(req), .addr(addr), .flush(flush),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .instr(instr_o[1]), .valid(valid_o[1]), .busy(busy_o[1]), .err(err_o[1])
  );

  fetch_resp #(.LATENCY(4), .DEPTH_LOG2(8)) u_l4 (
    .clk(clk), .rst_n(rst_n), .req(req), .addr(addr), .flush(flush),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .instr(instr_o[2]), .valid(valid_o[2]), .busy(busy_o[2]), .err(err_o[2])
  );

  function automatic void check(input string name, input int inst,
                                input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s dut%0d: got %h, expected %h", name, inst, act, exp);
    end
  endfunction

  // ---------------- behavioural model ----------------
  logic [15:0] mm [256];
  bit          pend  [3];
  int          left  [3];
  logic [15:0] word  [3];
  bit          errp  [3];
  bit          okp   [3];
  int          idxp  [3];
  logic        exp_valid [3] = '{1'b0, 1'b0, 1'b0};
  logic        exp_busy  [3] = '{1'b0, 1'b0, 1'b0};
  logic        exp_err   [3] = '{1'b0, 1'b0, 1'b0};
  logic [15:0] exp_instr [3] = '{16'h0, 16'h0, 16'h0};

  always @(posedge clk or negedge rst_n) begin : model
    if (!rst_n) begin
      for (int i = 0; i < 3; i++) begin
        pend[i]      <= 1'b0;
        left[i]      <= 0;
        exp_valid[i] <= 1'b0;
        exp_busy[i]  <= 1'b0;
        exp_err[i]   <= 1'b0;
        exp_instr[i] <= 16'h0000;
      end
    end else begin
      for (int i = 0; i < 3; i++) begin
        automatic bit          p, e, ok, live, ev;
        automatic int          l, ix;
        automatic logic [15:0] w;
        p = pend[i]; l = left[i]; w = word[i]; e = errp[i]; ok = okp[i]; ix = idxp[i];
        live = 1'b0; ev = 1'b0;
        if (p) begin
          if (flush) p = 1'b0;
          else begin
            live = 1'b1;
            l = l - 1;
            if (l == 0) begin ev = 1'b1; p = 1'b0; end
          end
        end else if (req && !flush) begin
          live = 1'b1;
          ix = int'(addr[8:1]);
          e  = addr[0];
          ok = (addr[15:9] == 7'd0) && !addr[0];
          w  = ok ? mm[addr[8:1]] : 16'h0800;
          l  = lat[i] - 1;
          if (l == 0) ev = 1'b1; else p = 1'b1;
        end
`ifdef FETCH_RESP_WR_FWD_EN
        if (live && ok && wr_en && (wr_addr[15:9] == 7'd0) && (int'(wr_addr[8:1]) == ix))
          w = wr_data;
`endif
        pend[i] <= p; left[i] <= l; word[i] <= w; errp[i] <= e; okp[i] <= ok; idxp[i] <= ix;
        exp_valid[i] <= ev;
        exp_busy[i]  <= p;
        exp_instr[i] <= w;
        exp_err[i]   <= ev && e;
      end
      if (wr_en && (wr_addr[15:9] == 7'd0)) mm[wr_addr[8:1]] <= wr_data;
    end
  end

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      for (int i = 0; i < 3; i++) begin
        check("valid", i, 16'(valid_o[i]), 16'(exp_valid[i]));
        check("busy", i, 16'(busy_o[i]), 16'(exp_busy[i]));
        if (exp_valid[i]) begin
          check("instr", i, instr_o[i], exp_instr[i]);
          check("err", i, 16'(err_o[i]), 16'(exp_err[i]));
        end
      end
    end
  end

  task automatic nclk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check_zero(input string tag);
    for (int i = 0; i < 3; i++) begin
      check({tag, "_instr"}, i, instr_o[i], 16'h0000);
      check({tag, "_valid"}, i, 16'(valid_o[i]), 16'h0000);
      check({tag, "_busy"}, i, 16'(busy_o[i]), 16'h0000);
      check({tag, "_err"}, i, 16'(err_o[i]), 16'h0000);
    end
  endtask

  logic [15:0] fwd_w;
  logic [15:0] same_w;

  initial begin
`ifdef FETCH_RESP_WR_FWD_EN
    fwd_w  = 16'h2222;
    same_w = 16'h3333;
`else
    fwd_w  = 16'h1111;
    same_w = 16'h2222;
`endif
    rst_n = 1'b1; req = 1'b0; addr = '0; flush = 1'b0;
    wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    #2 rst_n = 1'b0;
    chk_en = 1'b1;
    @(negedge clk);
    check_zero("reset");
    #2 rst_n = 1'b1;

    // Fill store: word j = (j*0x131) ^ 0xA5A5.
    for (int j = 0; j < 256; j++) begin
      wr_en = 1'b1; wr_addr = 16'(j * 2); wr_data = 16'(j * 16'h0131) ^ 16'hA5A5;
      @(negedge clk);
    end
    wr_en = 1'b0;
    nclk(2);

    // Back-to-back fetches of 0x0000, 0x0002, 0x0004 with req held.
    req = 1'b1; addr = 16'h0000;
    @(negedge clk);
    check("b2b0_valid", 1, 16'(valid_o[1]), 16'h0001);
    check("b2b0_instr", 1, instr_o[1], 16'hA5A5);
    check("b2b0_busy", 0, 16'(busy_o[0]), 16'h0001);
    addr = 16'h0002;
    @(negedge clk);
    check("b2b1_valid", 1, 16'(valid_o[1]), 16'h0001);
    check("b2b1_instr", 1, instr_o[1], 16'hA494);
    check("b2b1_l2instr", 0, instr_o[0], 16'hA5A5);
    addr = 16'h0004;
    @(negedge clk);
    check("b2b2_valid", 1, 16'(valid_o[1]), 16'h0001);
    check("b2b2_instr", 1, instr_o[1], 16'hA7C7);
    req = 1'b0;
    nclk(6);

    // Write then fetch 0x0004.
    wr_en = 1'b1; wr_addr = 16'h0004; wr_data = 16'hC123;
    @(negedge clk);
    wr_en = 1'b0; req = 1'b1; addr = 16'h0004;
    @(negedge clk);
    check("c123_busy", 0, 16'(busy_o[0]), 16'h0001);
    check("c123_early", 0, 16'(valid_o[0]), 16'h0000);
    req = 1'b0;
    @(negedge clk);
    check("c123_valid", 0, 16'(valid_o[0]), 16'h0001);
    check("c123_instr", 0, instr_o[0], 16'hC123);
    check("c123_err", 0, 16'(err_o[0]), 16'h0000);
    nclk(6);

    // Misaligned fetch.
    req = 1'b1; addr = 16'h0005;
    @(negedge clk);
    check("mis_err_l1", 1, 16'(err_o[1]), 16'h0001);
    req = 1'b0;
    @(negedge clk);
    check("mis_instr", 0, instr_o[0], 16'h0800);
    check("mis_err", 0, 16'(err_o[0]), 16'h0001);
    nclk(6);

    // Out-of-range fetch.
    req = 1'b1; addr = 16'h0400;
    @(negedge clk);
    req = 1'b0;
    @(negedge clk);
    check("oor_valid", 0, 16'(valid_o[0]), 16'h0001);
    check("oor_instr", 0, instr_o[0], 16'h0800);
    check("oor_err", 0, 16'(err_o[0]), 16'h0000);
    nclk(6);

    // Flush in second WAIT cycle of the LATENCY=4 instance, then refetch.
    req = 1'b1; addr = 16'h0002;
    @(negedge clk);
    req = 1'b0;
    check("fl_busy0", 2, 16'(busy_o[2]), 16'h0001);
    @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    check("fl_busy_drop", 2, 16'(busy_o[2]), 16'h0000);
    req = 1'b1; addr = 16'h0006;
    @(negedge clk);
    req = 1'b0;
    check("fl_reacc_busy", 2, 16'(busy_o[2]), 16'h0001);
    check("fl_no_valid", 2, 16'(valid_o[2]), 16'h0000);
    nclk(3);
    check("fl_re_valid", 2, 16'(valid_o[2]), 16'h0001);
    check("fl_re_instr", 2, instr_o[2], 16'hA636);
    nclk(6);

    // Write during WAIT; odd write address and out-of-range write on the side.
    wr_en = 1'b1; wr_addr = 16'h0011; wr_data = 16'h1111;
    @(negedge clk);
    wr_addr = 16'h0410; wr_data = 16'hBEEF;
    @(negedge clk);
    wr_en = 1'b0; req = 1'b1; addr = 16'h0010;
    @(negedge clk);
    check("ww_l1", 1, instr_o[1], 16'h1111);
    req = 1'b0; wr_en = 1'b1; wr_addr = 16'h0010; wr_data = 16'h2222;
    @(negedge clk);
    wr_en = 1'b0;
    check("ww_l2", 0, instr_o[0], fwd_w);
    nclk(2);
    check("ww_l4_valid", 2, 16'(valid_o[2]), 16'h0001);
    check("ww_l4", 2, instr_o[2], fwd_w);
    nclk(6);

    // Write and accept on the same edge, same index.
    wr_en = 1'b1; wr_addr = 16'h0010; wr_data = 16'h3333;
    req = 1'b1; addr = 16'h0010;
    @(negedge clk);
    wr_en = 1'b0; req = 1'b0;
    check("same_l1", 1, instr_o[1], same_w);
    @(negedge clk);
    check("same_l2", 0, instr_o[0], same_w);
    nclk(6);

    // Reset during WAIT.
    req = 1'b1; addr = 16'h0004;
    @(negedge clk);
    req = 1'b0;
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1 check_zero("midrst");
    @(negedge clk);
    #2 rst_n = 1'b1;
    nclk(8);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
